ctr_load_arbiter: RTL

Controller that owns one 8-bit synchronous load/increment counter, the block with an active-low sync reset, load, d[7:0] and a carry-out co.
- Sequences the counter's reset: holds it in reset for a guaranteed number of cycles after any system reset or software clear.
- Arbitrates load requests from two requesters with round-robin priority over a valid/ready handshake, then drives the counter's load/d pins.
- Counts counter wrap events for software.

---
 rtl/ctr_load_arbiter_if.sv | 19 +
 rtl/ctr_load_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/ctr_load_arbiter_if.sv
// Load-request handshake between requesters and the arbiter.
// req_valid/req_data from requesters, req_ready back per requester.
interface ctr_load_arbiter_if;
   logic [1:0]  req_valid;
   logic [15:0] req_data;
   logic [1:0]  req_ready;

   modport master (
      output req_valid,
      output req_data,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_data,
      output req_ready
   );
endinterface

// File: rtl/ctr_load_arbiter.sv
// Owns one 8-bit load/increment counter: reset sequencing, round-robin
// load arbitration (req), counter drive (ctr_*), wrap count/irq, busy.
module ctr_load_arbiter #(
   parameter int RST_CYCLES = 3,
   parameter int MIN_GAP    = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sw_clr,
   ctr_load_arbiter_if.slave    req,
   output logic                 ctr_rst_n,
   output logic                 ctr_load,
   output logic [7:0]           ctr_d,
   input  logic                 ctr_co,
   output logic                 gnt_id,
   output logic [15:0]          wrap_cnt,
   output logic                 wrap_irq,
   output logic                 busy
);

   localparam int CMAX = (RST_CYCLES > MIN_GAP) ? RST_CYCLES : MIN_GAP;
   localparam int CW   = $clog2(CMAX + 1);

   localparam logic [CW-1:0] HOLD_LAST = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST  =
      (MIN_GAP > 0) ? CW'(MIN_GAP - 1) : '0;

   typedef enum logic [1:0] {
      HOLD = 2'd0,
      RUN  = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          rr;

   logic [1:0]    gnt;
   logic          xfer;
   logic          sel;
   logic [7:0]    sel_data;

   // Grant is built only from valid, state and the rr pointer, so it
   // never loops back through req_ready.  rst/sw_clr block transfers.
   always_comb begin
      gnt = 2'b00;
      if (state == RUN && !rst && !sw_clr) begin
         unique case (1'b1)
            (req.req_valid == 2'b11): gnt = rr ? 2'b10 : 2'b01;
            default:                  gnt = req.req_valid;
         endcase
      end
   end

   assign req.req_ready = gnt;
   assign xfer          = |gnt;
   assign sel           = gnt[1];
   assign sel_data      = sel ? req.req_data[15:8] : req.req_data[7:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= HOLD;
         cnt       <= '0;
         rr        <= 1'b0;
         ctr_rst_n <= 1'b0;
         ctr_load  <= 1'b0;
         ctr_d     <= 8'h00;
         gnt_id    <= 1'b0;
         wrap_cnt  <= 16'h0000;
         wrap_irq  <= 1'b0;
         busy      <= 1'b1;
      end else begin
         // Carry-out is meaningless while the counter is held in reset.
         if (state != HOLD && ctr_co) begin
            wrap_irq <= 1'b1;
            if (wrap_cnt != 16'hFFFF)
               wrap_cnt <= wrap_cnt + 16'd1;
         end else begin
            wrap_irq <= 1'b0;
         end

         if (sw_clr) begin
            state     <= HOLD;
            cnt       <= '0;
            ctr_rst_n <= 1'b0;
            ctr_load  <= 1'b0;
            busy      <= 1'b1;
         end else begin
            unique case (state)
               HOLD: begin
                  ctr_load <= 1'b0;
                  if (cnt == HOLD_LAST) begin
                     state     <= RUN;
                     cnt       <= '0;
                     ctr_rst_n <= 1'b1;
                     busy      <= 1'b0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               RUN: begin
                  if (xfer) begin
                     ctr_load <= 1'b1;
                     ctr_d    <= sel_data;
                     gnt_id   <= sel;
                     rr       <= ~sel;
                     cnt      <= '0;
                     if (MIN_GAP > 0) begin
                        state <= GAP;
                        busy  <= 1'b1;
                     end
                  end else begin
                     ctr_load <= 1'b0;
                  end
               end
               GAP: begin
                  ctr_load <= 1'b0;
                  if (cnt == GAP_LAST) begin
                     state <= RUN;
                     cnt   <= '0;
                     busy  <= 1'b0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: begin
                  state     <= HOLD;
                  cnt       <= '0;
                  ctr_rst_n <= 1'b0;
                  ctr_load  <= 1'b0;
                  busy      <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule
